// File: rtl/apb_event_ctrl.sv
// APB event/interrupt controller: per-channel pending latches (edge or level),
// a prioritised interrupt request, and a RUN/SLEEP/WAKE machine gating fetch.
module apb_event_ctrl #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NUM_IRQ        = 32,
    parameter int NUM_EVT        = 32,
    parameter bit FETCH_EN_RST   = 1'b1
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NUM_IRQ-1:0]        irq_i,
    input  logic [NUM_EVT-1:0]        event_i,
    output logic                      irq_o,
    output logic [4:0]                irq_id_o,
    output logic                      fetch_enable_o,
    output logic [1:0]                dbg_state
);

    localparam logic [31:0] IRQ_MASK  = 32'hFFFF_FFFF >> (32 - NUM_IRQ);
    localparam logic [31:0] EVT_MASK  = 32'hFFFF_FFFF >> (32 - NUM_EVT);
    localparam logic [31:0] MODE_MASK = IRQ_MASK | EVT_MASK;

    localparam logic [3:0] A_IRQ_EN   = 4'd0;
    localparam logic [3:0] A_IRQ_PEND = 4'd1;
    localparam logic [3:0] A_IRQ_ACK  = 4'd2;
    localparam logic [3:0] A_EVT_EN   = 4'd3;
    localparam logic [3:0] A_EVT_PEND = 4'd4;
    localparam logic [3:0] A_EVT_ACK  = 4'd5;
    localparam logic [3:0] A_SLEEP    = 4'd6;
    localparam logic [3:0] A_STATUS   = 4'd7;
    localparam logic [3:0] A_MODE     = 4'd8;
    localparam logic [3:0] A_CYCLES   = 4'd9;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_SLEEP = 2'd1,
        ST_WAKE  = 2'd2
    } state_t;

    state_t      state, state_n;
    logic [31:0] irq_en, irq_pend, evt_en, evt_pend, irq_mode;
    logic [31:0] irq_prev, evt_prev;
    logic [31:0] sleep_cycles;
    logic        sleep_req, sleep_req_n;
    logic        fetch_ok;

    logic [3:0]  idx;
    logic        wr_en;
    logic [31:0] irq_in, evt_in, irq_hw, evt_hw, irq_active;
    logic [31:0] irq_pend_n, evt_pend_n;
    logic        wake;
    logic        wr_sleep;
    logic        addr_unused;
    logic [31:0] rdata;

    // APB handshake: a transfer is accepted on the HCLK edge where PSEL && PENABLE;
    // PREADY is held at 1, so every access phase completes in a single cycle.
    assign PREADY      = 1'b1;
    assign idx         = PADDR[5:2];
    assign addr_unused = ^{PADDR[APB_ADDR_WIDTH-1:6], PADDR[1:0]};
    assign wr_en       = PSEL && PENABLE && PWRITE;
    assign PSLVERR     = PSEL && PENABLE && (idx > A_CYCLES);
    assign wr_sleep    = wr_en && (idx == A_SLEEP);

    assign irq_in = 32'(irq_i);
    assign evt_in = 32'(event_i);

    // Level channels set every cycle the line is high; edge channels only on 0->1.
    assign irq_hw = irq_in & (irq_mode | ~irq_prev);
    assign evt_hw = evt_in & (irq_mode | ~evt_prev);

    always_comb begin
        irq_pend_n = irq_pend;
        evt_pend_n = evt_pend;
        if (wr_en && idx == A_IRQ_ACK)  irq_pend_n = irq_pend_n & ~PWDATA;
        if (wr_en && idx == A_EVT_ACK)  evt_pend_n = evt_pend_n & ~PWDATA;
        if (wr_en && idx == A_IRQ_PEND) irq_pend_n = irq_pend_n | PWDATA;
        if (wr_en && idx == A_EVT_PEND) evt_pend_n = evt_pend_n | PWDATA;
        irq_pend_n = (irq_pend_n | irq_hw) & IRQ_MASK;
        evt_pend_n = (evt_pend_n | evt_hw) & EVT_MASK;
    end

    assign irq_active = irq_pend & irq_en;
    assign irq_o      = |irq_active;
    assign wake       = irq_o || (|(evt_pend & evt_en));

    always_comb begin
        irq_id_o = 5'd0;
        for (int k = 31; k >= 0; k--) begin
            if (irq_active[k]) irq_id_o = 5'(k);
        end
    end

    // The sleep request written this cycle acts immediately so SLEEP starts on the commit edge.
    always_comb begin
        state_n     = state;
        sleep_req_n = wr_sleep ? PWDATA[0] : sleep_req;
        case (state)
            ST_RUN: begin
                if (sleep_req_n) begin
                    if (wake) sleep_req_n = 1'b0;
                    else      state_n     = ST_SLEEP;
                end
            end
            ST_SLEEP: begin
                if (wake || (wr_sleep && !PWDATA[0])) state_n = ST_WAKE;
            end
            ST_WAKE: begin
                sleep_req_n = 1'b0;
                state_n     = ST_RUN;
            end
            default: state_n = ST_RUN;
        endcase
    end

    assign fetch_enable_o = (state == ST_WAKE) || (state == ST_RUN && fetch_ok);
    assign dbg_state      = state;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state        <= ST_RUN;
            irq_en       <= 32'h0;
            irq_pend     <= 32'h0;
            evt_en       <= 32'h0;
            evt_pend     <= 32'h0;
            irq_mode     <= 32'h0;
            irq_prev     <= 32'h0;
            evt_prev     <= 32'h0;
            sleep_cycles <= 32'h0;
            sleep_req    <= 1'b0;
            fetch_ok     <= FETCH_EN_RST;
        end else begin
            state     <= state_n;
            sleep_req <= sleep_req_n;
            irq_pend  <= irq_pend_n;
            evt_pend  <= evt_pend_n;
            irq_prev  <= irq_in;
            evt_prev  <= evt_in;
            if (wake || wr_sleep)            fetch_ok <= 1'b1;
            if (wr_en && idx == A_IRQ_EN)    irq_en   <= PWDATA & IRQ_MASK;
            if (wr_en && idx == A_EVT_EN)    evt_en   <= PWDATA & EVT_MASK;
            if (wr_en && idx == A_MODE)      irq_mode <= PWDATA & MODE_MASK;
            if (wr_en && idx == A_CYCLES) begin
                sleep_cycles <= 32'h0;
            end else if (state == ST_SLEEP && sleep_cycles != 32'hFFFF_FFFF) begin
                sleep_cycles <= sleep_cycles + 32'd1;
            end
        end
    end

    always_comb begin
        rdata = 32'h0;
        case (idx)
            A_IRQ_EN:   rdata = irq_en;
            A_IRQ_PEND: rdata = irq_pend;
            A_EVT_EN:   rdata = evt_en;
            A_EVT_PEND: rdata = evt_pend;
            A_SLEEP:    rdata = {31'h0, sleep_req};
            A_STATUS:   rdata = {29'h0, fetch_enable_o, irq_o, state == ST_SLEEP};
            A_MODE:     rdata = irq_mode;
            A_CYCLES:   rdata = sleep_cycles;
            default:    rdata = 32'h0;
        endcase
        PRDATA = (PSEL && !PWRITE) ? rdata : 32'h0;
    end

endmodule

// File: tb/tb_apb_event_ctrl.sv
// Directed bench for apb_event_ctrl: a full-width instance plus a narrow
// instance (4 channels, fetch enable low after reset) sharing the APB bus.
module tb_apb_event_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic [11:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE, PENABLE;
    logic        psel_a, psel_b;

    logic [31:0] irq_a, evt_a;
    logic [3:0]  irq_b, evt_b;

    logic [31:0] prdata_a, prdata_b;
    logic        pready_a, pready_b, pslverr_a, pslverr_b;
    logic        irq_o_a, irq_o_b, fetch_a, fetch_b;
    logic [4:0]  irq_id_a, irq_id_b;
    logic [1:0]  dbg_a, dbg_b;

    int checks   = 0;
    int failures = 0;

    localparam logic [1:0] S_RUN = 2'd0, S_SLEEP = 2'd1, S_WAKE = 2'd2;

    always #5 HCLK = ~HCLK;

    apb_event_ctrl #(.APB_ADDR_WIDTH(12), .NUM_IRQ(32), .NUM_EVT(32), .FETCH_EN_RST(1'b1)) dut_a (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(psel_a), .PENABLE(PENABLE), .PRDATA(prdata_a), .PREADY(pready_a),
        .PSLVERR(pslverr_a), .irq_i(irq_a), .event_i(evt_a), .irq_o(irq_o_a),
        .irq_id_o(irq_id_a), .fetch_enable_o(fetch_a), .dbg_state(dbg_a)
    );

    apb_event_ctrl #(.APB_ADDR_WIDTH(12), .NUM_IRQ(4), .NUM_EVT(4), .FETCH_EN_RST(1'b0)) dut_b (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(psel_b), .PENABLE(PENABLE), .PRDATA(prdata_b), .PREADY(pready_b),
        .PSLVERR(pslverr_b), .irq_i(irq_b), .event_i(evt_b), .irq_o(irq_o_b),
        .irq_id_o(irq_id_b), .fetch_enable_o(fetch_b), .dbg_state(dbg_b)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic apb_write(input bit b, input logic [11:0] addr, input logic [31:0] data);
        @(posedge HCLK); #1;
        psel_a = !b; psel_b = b; PWRITE = 1'b1; PADDR = addr; PWDATA = data; PENABLE = 1'b0;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(posedge HCLK); #1;
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input bit b, input logic [11:0] addr, output logic [31:0] data,
                            output logic err);
        @(posedge HCLK); #1;
        psel_a = !b; psel_b = b; PWRITE = 1'b0; PADDR = addr; PENABLE = 1'b0;
        @(posedge HCLK); #1;
        PENABLE = 1'b1;
        @(negedge HCLK);
        data = b ? prdata_b : prdata_a;
        err  = b ? pslverr_b : pslverr_a;
        @(posedge HCLK); #1;
        psel_a = 1'b0; psel_b = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic rd_chk(input bit b, input logic [11:0] addr, input logic [31:0] exp,
                          input string tag);
        logic [31:0] d;
        logic        e;
        apb_read(b, addr, d, e);
        check_val(tag, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        logic        e;

        HRESET = 1'b1; PADDR = '0; PWDATA = '0; PWRITE = 1'b0; PENABLE = 1'b0;
        psel_a = 1'b0; psel_b = 1'b0; irq_a = '0; evt_a = '0; irq_b = '0; evt_b = '0;

        // reset values
        #2;
        check_val("rst_fetch_a", 32'(fetch_a), 32'd1);
        check_val("rst_fetch_b", 32'(fetch_b), 32'd0);
        check_val("rst_irq_o", 32'(irq_o_a), 32'd0);
        check_val("rst_irq_id", 32'(irq_id_a), 32'd0);
        check_val("rst_pready", 32'(pready_a), 32'd1);
        check_val("rst_pslverr", 32'(pslverr_a), 32'd0);
        check_val("rst_prdata", prdata_a, 32'd0);
        check_val("rst_state", 32'(dbg_a), 32'(S_RUN));
        @(posedge HCLK); @(posedge HCLK); #1;
        HRESET = 1'b0;
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        check_val("b_fetch_held", 32'(fetch_b), 32'd0);

        // narrow instance: unimplemented bits, fetch released by first wake
        apb_write(1'b1, 12'h000, 32'h0000_00FF);
        @(negedge HCLK);
        check_val("b_fetch_after_en", 32'(fetch_b), 32'd0);
        rd_chk(1'b1, 12'h000, 32'h0000_000F, "b_irq_en_mask");
        apb_write(1'b1, 12'h004, 32'h0000_00FF);
        rd_chk(1'b1, 12'h004, 32'h0000_000F, "b_irq_pend_mask");
        check_val("b_irq_o", 32'(irq_o_b), 32'd1);
        check_val("b_fetch_woken", 32'(fetch_b), 32'd1);

        // edge mode: held line sets pending once, ACK clears it for good
        apb_write(1'b0, 12'h000, 32'h0000_0001);
        irq_a = 32'h1;
        @(negedge HCLK);
        check_val("edge_latency", 32'(irq_o_a), 32'd0);
        @(negedge HCLK);
        check_val("edge_irq_o", 32'(irq_o_a), 32'd1);
        apb_write(1'b0, 12'h008, 32'h0000_0001);
        @(posedge HCLK); #1;
        irq_a = 32'h0;
        rd_chk(1'b0, 12'h004, 32'h0, "edge_pend_acked");

        // level mode: held line re-sets pending despite ACK
        apb_write(1'b0, 12'h020, 32'h0000_0001);
        rd_chk(1'b0, 12'h020, 32'h0000_0001, "mode_rd");
        irq_a = 32'h1;
        @(posedge HCLK); #1;
        apb_write(1'b0, 12'h008, 32'h0000_0001);
        rd_chk(1'b0, 12'h004, 32'h0000_0001, "level_reset");
        irq_a = 32'h0;
        @(posedge HCLK); #1;
        apb_write(1'b0, 12'h008, 32'h0000_0001);
        rd_chk(1'b0, 12'h004, 32'h0, "level_cleared");
        apb_write(1'b0, 12'h020, 32'h0);

        // priority encoding with masked low channels
        apb_write(1'b0, 12'h000, 32'hFFFF_FFF0);
        rd_chk(1'b0, 12'h000, 32'hFFFF_FFF0, "irq_en_rd");
        @(posedge HCLK); #1;
        irq_a = 32'h8000_0084;
        @(posedge HCLK); #1;
        irq_a = 32'h0;
        @(negedge HCLK);
        check_val("prio_irq_o", 32'(irq_o_a), 32'd1);
        check_val("prio_id7", 32'(irq_id_a), 32'd7);
        rd_chk(1'b0, 12'h004, 32'h8000_0084, "prio_pend");
        apb_write(1'b0, 12'h008, 32'h0000_0080);
        @(negedge HCLK);
        check_val("prio_id31", 32'(irq_id_a), 32'd31);
        apb_write(1'b0, 12'h008, 32'h8000_0004);
        @(negedge HCLK);
        check_val("prio_none_irq_o", 32'(irq_o_a), 32'd0);
        check_val("prio_none_id", 32'(irq_id_a), 32'd0);
        apb_write(1'b0, 12'h004, 32'h0000_00FF);
        @(negedge HCLK);
        check_val("sw_set_id4", 32'(irq_id_a), 32'd4);
        apb_write(1'b0, 12'h008, 32'hFFFF_FFFF);
        rd_chk(1'b0, 12'h004, 32'h0, "sw_set_acked");

        // ACK colliding with a rising edge on the same channel
        apb_write(1'b0, 12'h004, 32'h0000_0020);
        @(posedge HCLK); #1;
        psel_a = 1'b1; PWRITE = 1'b1; PADDR = 12'h008; PWDATA = 32'h20; PENABLE = 1'b0;
        @(posedge HCLK); #1;
        PENABLE = 1'b1; irq_a = 32'h20;
        @(posedge HCLK); #1;
        psel_a = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; irq_a = 32'h0;
        rd_chk(1'b0, 12'h004, 32'h0000_0020, "collision_pend");
        check_val("collision_id", 32'(irq_id_a), 32'd5);
        apb_write(1'b0, 12'h008, 32'h0000_0020);
        rd_chk(1'b0, 12'h004, 32'h0, "collision_acked");

        // unmapped word indices
        apb_read(1'b0, 12'h028, d, e);
        check_val("slverr_28", 32'(e), 32'd1);
        check_val("slverr_28_data", d, 32'd0);
        apb_read(1'b0, 12'h03C, d, e);
        check_val("slverr_3c", 32'(e), 32'd1);
        apb_read(1'b0, 12'h024, d, e);
        check_val("slverr_24", 32'(e), 32'd0);

        // sleep then event wake: 11 cycles asleep
        apb_write(1'b0, 12'h00C, 32'h0000_0001);
        apb_write(1'b0, 12'h018, 32'h0000_0001);
        @(negedge HCLK);
        check_val("sleep_fetch", 32'(fetch_a), 32'd0);
        check_val("sleep_state", 32'(dbg_a), 32'(S_SLEEP));
        repeat (9) @(posedge HCLK);
        #1 evt_a = 32'h1;
        @(posedge HCLK); #1;
        evt_a = 32'h0;
        @(negedge HCLK);
        check_val("wake_not_yet", 32'(fetch_a), 32'd0);
        @(negedge HCLK);
        check_val("wake_fetch", 32'(fetch_a), 32'd1);
        check_val("wake_state", 32'(dbg_a), 32'(S_WAKE));
        @(negedge HCLK);
        check_val("run_state", 32'(dbg_a), 32'(S_RUN));
        rd_chk(1'b0, 12'h024, 32'd11, "sleep_cycles");
        rd_chk(1'b0, 12'h018, 32'd0, "sleep_ctrl_clr");
        rd_chk(1'b0, 12'h01C, 32'h4, "status_run");
        apb_write(1'b0, 12'h014, 32'h0000_0001);
        rd_chk(1'b0, 12'h010, 32'h0, "evt_acked");
        apb_write(1'b0, 12'h024, 32'h0000_1234);
        rd_chk(1'b0, 12'h024, 32'd0, "cycles_cleared");

        // request dropped while an event is pending
        apb_write(1'b0, 12'h00C, 32'h0000_0009);
        apb_write(1'b0, 12'h010, 32'h0000_0008);
        rd_chk(1'b0, 12'h010, 32'h0000_0008, "evt_sw_set");
        apb_write(1'b0, 12'h018, 32'h0000_0001);
        @(negedge HCLK);
        check_val("drop_fetch", 32'(fetch_a), 32'd1);
        check_val("drop_state", 32'(dbg_a), 32'(S_RUN));
        rd_chk(1'b0, 12'h018, 32'd0, "drop_sleep_ctrl");
        apb_write(1'b0, 12'h014, 32'h0000_0008);

        // software wake by clearing the request while asleep
        apb_write(1'b0, 12'h018, 32'h0000_0001);
        @(negedge HCLK);
        check_val("sw_sleep_state", 32'(dbg_a), 32'(S_SLEEP));
        repeat (3) @(posedge HCLK);
        apb_write(1'b0, 12'h018, 32'h0000_0000);
        @(negedge HCLK);
        check_val("sw_wake_state", 32'(dbg_a), 32'(S_WAKE));
        check_val("sw_wake_fetch", 32'(fetch_a), 32'd1);
        @(negedge HCLK);
        check_val("sw_wake_run", 32'(dbg_a), 32'(S_RUN));
        rd_chk(1'b0, 12'h024, 32'd6, "sw_sleep_cycles");

        // asynchronous reset while asleep, observed between clock edges
        apb_write(1'b0, 12'h018, 32'h0000_0001);
        @(negedge HCLK);
        check_val("pre_rst_state", 32'(dbg_a), 32'(S_SLEEP));
        #1 HRESET = 1'b1;
        #1;
        check_val("arst_fetch_a", 32'(fetch_a), 32'd1);
        check_val("arst_state", 32'(dbg_a), 32'(S_RUN));
        check_val("arst_fetch_b", 32'(fetch_b), 32'd0);
        check_val("arst_irq_o_b", 32'(irq_o_b), 32'd0);
        psel_a = 1'b1; PWRITE = 1'b0; PADDR = 12'h000;
        #1;
        check_val("arst_irq_en", prdata_a, 32'd0);
        PADDR = 12'h01C;
        #1;
        check_val("arst_status", prdata_a, 32'h4);
        psel_a = 1'b0;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        rd_chk(1'b0, 12'h018, 32'd0, "post_rst_sleep_ctrl");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
